digit_frame_loader: RTL and testbench

//   Front end for digit_recognition. Accepts a raster pixel stream (valid/ready), assembles one
//   28x28 8-bit frame in a private frame RAM and checks the frame length. It then presents the frame
//   to the recognizer through a synchronous read port and collects the recognizer's digit.
//   It emits one result per frame, or an error result on a length fault or recognizer timeout.

---
 rtl/digit_pkg.sv | 24 ++
 rtl/digit_frame_ram.sv | 30 +++
 rtl/digit_frame_loader.sv | 174 +++++++++++++++++
 tb/tb_digit_frame_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_pkg.sv
// Shared definitions for the digit recognition front end.
//   IMG_PIXELS    : pixels in one 28x28 frame
//   PIX_W         : bits per pixel
//   DIGIT_INVALID : digit code reported with every error result
//   loader_state_e: frame loader FSM states
package digit_pkg;

  localparam int unsigned IMG_PIXELS    = 784;
  localparam int unsigned PIX_W         = 8;
  localparam logic [3:0]  DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StHold,
    StResult
  } loader_state_e;

  // Recognizer digits above 9 are not decimal digits and are reported as errors.
  function automatic logic digit_in_range(logic [3:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_frame_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// Contents are not reset, which keeps the array inferable as block RAM.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data, valid one cycle after rd_addr
module digit_frame_ram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned PIX_W  = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/digit_frame_loader.sv
// Frame loader in front of the digit recognizer. Collects one raster frame from a
// valid/ready pixel stream, checks its length, exposes it through a synchronous read
// port while the recognizer works, and reports one result (or error) per frame.
//   clk, rst_n              : clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  : pixel stream handshake and data
//   s_sof, s_last           : frame start / frame end markers, qualified by s_valid
//   frame_valid             : a complete frame is held in RAM
//   rd_addr, rd_data        : recognizer read port, one cycle latency, 0 outside the frame
//   rec_done, rec_digit     : recognizer completion pulse and its digit
//   res_valid               : one-cycle result pulse
//   res_digit, res_err      : result digit (F on error) and error flag, held between pulses
module digit_frame_loader #(
  parameter int unsigned IMG_W       = 28,
  parameter int unsigned IMG_H       = 28,
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_sof,
  input  logic              s_last,
  output logic              frame_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  input  logic              rec_done,
  input  logic [3:0]        rec_digit,
  output logic              res_valid,
  output logic [3:0]        res_digit,
  output logic              res_err
);

  import digit_pkg::*;

  localparam int unsigned FramePix = IMG_W * IMG_H;
  localparam int unsigned TmoW     = $clog2(TIMEOUT_CYC + 1);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FramePix - 1);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYC - 1);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [3:0]        res_digit_q, res_digit_d;
  logic              res_err_q, res_err_d;
  logic              rd_ok_q;

  logic              beat;
  logic              fault;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [PIX_W-1:0]  ram_rd_data;

  assign beat = s_valid & s_ready_q;
  // s_sof always restarts the frame, so the write index falls back to 0.
  assign wr_idx = s_sof ? '0 : pix_cnt_q;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    res_valid_d = 1'b0;
    res_digit_d = res_digit_q;
    res_err_d   = res_err_q;
    fault       = 1'b0;
    wr_en       = 1'b0;

    unique case (state_q)
      StIdle, StFill: begin
        // In IDLE only a start-of-frame beat is taken; anything else is dropped.
        if (beat && (s_sof || state_q == StFill)) begin
          wr_en = 1'b1;
          if (s_last) begin
            if (wr_idx == LastAddr) begin
              state_d   = StHold;
              pix_cnt_d = '0;
              tmo_cnt_d = '0;
            end else begin
              fault = 1'b1;
            end
          end else if (wr_idx == LastAddr) begin
            fault = 1'b1;
          end else begin
            state_d   = StFill;
            pix_cnt_d = wr_idx + 1'b1;
          end
        end
      end
      StHold: begin
        // A completion in the final timeout cycle still counts as a result.
        if (rec_done) begin
          state_d     = StResult;
          res_valid_d = 1'b1;
          if (digit_in_range(rec_digit)) begin
            res_digit_d = rec_digit;
            res_err_d   = 1'b0;
          end else begin
            res_digit_d = DIGIT_INVALID;
            res_err_d   = 1'b1;
          end
        end else if (tmo_cnt_q == TmoLast) begin
          fault = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      StResult: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (fault) begin
      state_d     = StIdle;
      pix_cnt_d   = '0;
      res_valid_d = 1'b1;
      res_digit_d = DIGIT_INVALID;
      res_err_d   = 1'b1;
    end

    // Registered from the next state so s_ready stays low throughout reset.
    s_ready_d = (state_d == StIdle) || (state_d == StFill);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_digit_q <= '0;
      res_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      s_ready_q   <= s_ready_d;
      res_valid_q <= res_valid_d;
      res_digit_q <= res_digit_d;
      res_err_q   <= res_err_d;
      rd_ok_q     <= {1'b0, rd_addr} < (ADDR_W + 1)'(FramePix);
    end
  end

  digit_frame_ram #(
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_idx),
    .wr_data (s_data),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // RAM output is unreset and may hold stale data above the frame; rd_ok_q masks both cases.
  assign rd_data     = rd_ok_q ? ram_rd_data : '0;
  assign s_ready     = s_ready_q;
  assign frame_valid = (state_q == StHold) || (state_q == StResult);
  assign res_valid   = res_valid_q;
  assign res_digit   = res_digit_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_digit_frame_loader.sv
// Directed and randomized bench for digit_frame_loader. Expected frames, digits and
// error outcomes come from simple arithmetic on the frame rules.
module tb_digit_frame_loader;

  localparam int Pix = 784;
  localparam int Tmo = 4096;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_sof = 1'b0;
  logic       s_last = 1'b0;
  logic [9:0] rd_addr = '0;
  logic       rec_done = 1'b0;
  logic [3:0] rec_digit = '0;
  logic       s_ready, frame_valid, res_valid, res_err;
  logic [7:0] rd_data;
  logic [3:0] res_digit;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int exp_pulses = 0;
  logic [7:0] ref_mem [Pix];

  digit_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .s_last      (s_last),
    .frame_valid (frame_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rec_done    (rec_done),
    .rec_digit   (rec_digit),
    .res_valid   (res_valid),
    .res_digit   (res_digit),
    .res_err     (res_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (res_valid === 1'b1) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge; returns once the beat has been taken by a posedge.
  task automatic send_beat(input logic [7:0] d, input logic sof, input logic last, input int gap);
    bit acc;
    int n;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      acc = (s_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_last  = 1'b0;
    if (!acc) chk("beat_accept", 0, 1);
  endtask

  task automatic send_frame(input int n, input int last_at, input bit rnd, input int max_gap);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom) : i[7:0];
      if (i < Pix) ref_mem[i] = d;
      send_beat(d, i == 0, i == last_at, (max_gap > 0) ? $urandom_range(0, max_gap) : 0);
    end
  endtask

  task automatic read_all(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < Pix; a++) begin
      rd_addr = 10'(a);
      @(negedge clk);
      if (rd_data !== ref_mem[a]) begin
        if (bad == 0) $display("first bad read at addr %0d: %0h vs %0h", a, rd_data, ref_mem[a]);
        bad++;
      end
    end
    chk({tag, "_bad_reads"}, bad, 0);
    rd_addr = 10'd784;
    @(negedge clk);
    chk({tag, "_rd_oob784"}, rd_data, 0);
    rd_addr = 10'd1023;
    @(negedge clk);
    chk({tag, "_rd_oob1023"}, rd_data, 0);
  endtask

  // Frame is in HOLD: pulse rec_done and check the resulting one-cycle result.
  task automatic finish_frame(input string tag, input logic [3:0] d);
    logic [3:0] ed;
    logic       ee;
    ee = (d > 4'd9);
    ed = ee ? 4'hF : d;
    chk({tag, "_hold_fv"}, frame_valid, 1);
    chk({tag, "_hold_rdy"}, s_ready, 0);
    rec_done  = 1'b1;
    rec_digit = d;
    @(negedge clk);
    rec_done  = 1'b0;
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_digit"}, res_digit, ed);
    chk({tag, "_res_err"}, res_err, ee);
    exp_pulses++;
    @(negedge clk);
    chk({tag, "_pulse_end"}, res_valid, 0);
    chk({tag, "_digit_held"}, res_digit, ed);
    chk({tag, "_ready_again"}, s_ready, 1);
    chk({tag, "_fv_low"}, frame_valid, 0);
  endtask

  task automatic chk_err_pulse(input string tag);
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_err"}, res_err, 1);
    chk({tag, "_digit"}, res_digit, 4'hF);
    chk({tag, "_fv"}, frame_valid, 0);
    exp_pulses++;
  endtask

  initial begin
    int n;
    logic [3:0] d;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_digit", res_digit, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    #1 chk("rdy_before_edge", s_ready, 0);
    @(negedge clk);
    chk("rdy_after_release", s_ready, 1);

    // Counting-pattern frame, readback, digit 3
    send_frame(Pix, Pix - 1, 1'b0, 0);
    chk("a_fv_next_cycle", frame_valid, 1);
    chk("a_no_result", res_valid, 0);
    read_all("a");
    finish_frame("a", 4'd3);

    // rec_done outside HOLD is ignored
    rec_done  = 1'b1;
    rec_digit = 4'd5;
    @(negedge clk);
    rec_done = 1'b0;
    chk("idle_recdone_ignored", res_valid, 0);
    chk("idle_digit_held", res_digit, 3);

    // Short frame: last on beat 500
    send_frame(501, 500, 1'b1, 2);
    chk_err_pulse("short");
    @(negedge clk);
    chk("short_pulse_end", res_valid, 0);
    chk("short_digit_held", res_digit, 4'hF);
    send_frame(Pix, Pix - 1, 1'b1, 1);
    chk("b_fv", frame_valid, 1);
    read_all("b");
    finish_frame("b", 4'd9);

    // Long frame: 790 beats, no last
    for (int i = 0; i < 790; i++) begin
      send_beat(8'($urandom), i == 0, 1'b0, 0);
      if (i == 782) chk("long_no_early_err", res_valid, 0);
      if (i == 783) chk_err_pulse("long");
      if (i == 784) chk("long_pulse_end", res_valid, 0);
    end
    chk("long_trail_fv", frame_valid, 0);
    chk("long_trail_ready", s_ready, 1);
    send_frame(Pix, Pix - 1, 1'b1, 0);
    finish_frame("c_digit12", 4'd12);

    // Mid-frame restart, then sof+last on one beat
    send_frame(300, -1, 1'b1, 1);
    send_frame(Pix, Pix - 1, 1'b1, 0);
    chk("restart_no_err", res_valid, 0);
    read_all("restart");
    finish_frame("restart", 4'd0);
    send_beat(8'h55, 1'b1, 1'b1, 0);
    chk_err_pulse("sof_last");

    // Recognizer timeout
    send_frame(Pix, Pix - 1, 1'b1, 0);
    n = 0;
    while (res_valid !== 1'b1 && n < Tmo + 1000) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, Tmo);
    chk("tmo_err", res_err, 1);
    chk("tmo_digit", res_digit, 4'hF);
    exp_pulses++;
    @(negedge clk);
    chk("tmo_idle_ready", s_ready, 1);
    chk("tmo_idle_fv", frame_valid, 0);

    // Randomized frames and digits
    for (int k = 0; k < 3; k++) begin
      send_frame(Pix, Pix - 1, 1'b1, 3);
      chk("rnd_fv", frame_valid, 1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
      d = 4'($urandom_range(0, 15));
      finish_frame("rnd", d);
    end
    read_all("rnd");

    // Reset in the middle of a frame
    send_frame(200, -1, 1'b1, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_fv", frame_valid, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_digit", res_digit, 0);
    chk("mid_rst_res_err", res_err, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", s_ready, 1);
    send_frame(Pix, Pix - 1, 1'b1, 2);
    chk("post_rst_fv", frame_valid, 1);
    read_all("post_rst");
    finish_frame("post_rst", 4'd7);

    repeat (5) @(negedge clk);
    chk("pulse_count", pulses, exp_pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
